// File: rtl/fizzbuzz_seq_ctrl_if.sv
// Stream and request bundle for the fizzbuzz run sequencer.
// Optional stats outputs appear with FIZZBUZZ_SEQ_CTRL_STATS_EN.
interface fizzbuzz_seq_ctrl_if #(
  parameter int W = 6
);
  logic         i_start_valid;
  logic         o_start_ready;
  logic [W-1:0] i_len;
  logic         i_abort;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_number;
  logic         o_is_fizz;
  logic         o_is_buzz;
  logic         o_last;
  logic         o_busy;
  logic         o_done;
  logic         o_aborted;
`ifdef FIZZBUZZ_SEQ_CTRL_STATS_EN
  logic [W-1:0] o_fizz_cnt;
  logic [W-1:0] o_buzz_cnt;
  logic [W-1:0] o_fizzbuzz_cnt;
`endif

  modport master (
    output i_start_valid, i_len, i_abort, i_ready,
    input  o_start_ready, o_valid, o_number,
    input  o_is_fizz, o_is_buzz, o_last,
    input  o_busy, o_done, o_aborted
`ifdef FIZZBUZZ_SEQ_CTRL_STATS_EN
    ,
    input  o_fizz_cnt, o_buzz_cnt, o_fizzbuzz_cnt
`endif
  );

  modport slave (
    input  i_start_valid, i_len, i_abort, i_ready,
    output o_start_ready, o_valid, o_number,
    output o_is_fizz, o_is_buzz, o_last,
    output o_busy, o_done, o_aborted
`ifdef FIZZBUZZ_SEQ_CTRL_STATS_EN
    ,
    output o_fizz_cnt, o_buzz_cnt, o_fizzbuzz_cnt
`endif
  );
endinterface

// File: rtl/fizzbuzz_seq_ctrl.sv
// Run sequencer: emits 1..N with fizz/buzz flags from modulo counters.
// Define FIZZBUZZ_SEQ_CTRL_STATS_EN to add per-run flag counters.
module fizzbuzz_seq_ctrl #(
  parameter int G_MAX_LEN  = 50,
  parameter int G_FIZZ_DIV = 3,
  parameter int G_BUZZ_DIV = 5
) (
  input logic           i_clk,
  input logic           i_rst_n,
  fizzbuzz_seq_ctrl_if.slave bus
);
  localparam int W  = $clog2(G_MAX_LEN + 1);
  localparam int FW = $clog2(G_FIZZ_DIV);
  localparam int BW = $clog2(G_BUZZ_DIV);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [W-1:0]  MAX_LEN  = W'(G_MAX_LEN);
  localparam logic [FW-1:0] FIZZ_TOP = FW'(G_FIZZ_DIV - 1);
  localparam logic [BW-1:0] BUZZ_TOP = BW'(G_BUZZ_DIV - 1);

  logic [1:0]    state;
  logic [W-1:0]  num;
  logic [W-1:0]  len_q;
  logic [W-1:0]  len_c;
  logic [FW-1:0] fizz_mod;
  logic [BW-1:0] buzz_mod;
  logic          aborted_q;
  logic          run;
  logic          accept;
  logic          xfer;
  logic          last;
  logic          fizz_hit;
  logic          buzz_hit;

  assign run      = (state == S_RUN);
  assign accept   = (state == S_IDLE) & bus.i_start_valid;
  assign xfer     = run & bus.i_ready;
  assign last     = (num == len_q);
  assign fizz_hit = (fizz_mod == '0);
  assign buzz_hit = (buzz_mod == '0);
  assign len_c    = (bus.i_len > MAX_LEN) ? MAX_LEN : bus.i_len;

  assign bus.o_start_ready = (state == S_IDLE);
  assign bus.o_valid       = run;
  assign bus.o_number      = num;
  assign bus.o_is_fizz     = run & fizz_hit;
  assign bus.o_is_buzz     = run & buzz_hit;
  assign bus.o_last        = run & last;
  assign bus.o_busy        = (state != S_IDLE);
  assign bus.o_done        = (state == S_DONE);
  assign bus.o_aborted     = (state == S_DONE) & aborted_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      num       <= '0;
      len_q     <= '0;
      fizz_mod  <= '0;
      buzz_mod  <= '0;
      aborted_q <= 1'b0;
    end else begin
      unique case (1'b1)
        state == S_IDLE: begin
          if (bus.i_start_valid) begin
            len_q     <= len_c;
            aborted_q <= 1'b0;
            if (len_c == '0) begin
              state <= S_DONE;
            end else begin
              state    <= S_RUN;
              num      <= W'(1);
              fizz_mod <= FW'(1);
              buzz_mod <= BW'(1);
            end
          end
        end
        state == S_RUN: begin
          // abort wins even when the sink takes the beat this cycle
          if (bus.i_abort) begin
            state     <= S_DONE;
            aborted_q <= 1'b1;
          end else if (bus.i_ready) begin
            if (last) begin
              state <= S_DONE;
            end else begin
              num      <= num + W'(1);
              fizz_mod <= (fizz_mod == FIZZ_TOP) ? '0 : fizz_mod + FW'(1);
              buzz_mod <= (buzz_mod == BUZZ_TOP) ? '0 : buzz_mod + BW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FIZZBUZZ_SEQ_CTRL_STATS_EN
  logic [W-1:0] fizz_cnt;
  logic [W-1:0] buzz_cnt;
  logic [W-1:0] fb_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || accept) begin
      fizz_cnt <= '0;
      buzz_cnt <= '0;
      fb_cnt   <= '0;
    end else if (xfer) begin
      if (fizz_hit && !buzz_hit) fizz_cnt <= fizz_cnt + W'(1);
      if (!fizz_hit && buzz_hit) buzz_cnt <= buzz_cnt + W'(1);
      if (fizz_hit && buzz_hit)  fb_cnt   <= fb_cnt + W'(1);
    end
  end

  assign bus.o_fizz_cnt     = fizz_cnt;
  assign bus.o_buzz_cnt     = buzz_cnt;
  assign bus.o_fizzbuzz_cnt = fb_cnt;
`else
  logic unused_xfer;
  assign unused_xfer = xfer & accept;
`endif
endmodule

// File: tb/tb_fizzbuzz_seq_ctrl.sv
// Directed bench for fizzbuzz_seq_ctrl with immediate-assertion checks.
// Stats counters are checked when FIZZBUZZ_SEQ_CTRL_STATS_EN is defined.
module tb_fizzbuzz_seq_ctrl;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  fizzbuzz_seq_ctrl_if #(.W(6)) bus ();

  fizzbuzz_seq_ctrl #(
    .G_MAX_LEN  (50),
    .G_FIZZ_DIV (3),
    .G_BUZZ_DIV (5)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start(input int len);
    bus.i_start_valid = 1'b1;
    bus.i_len         = 6'(len);
    tick();
    bus.i_start_valid = 1'b0;
  endtask

  initial begin
    int beats;
    int last_cnt;
    int last_num;
    int last_fz;
    int last_bz;
    rst_n             = 1'b0;
    bus.i_start_valid = 1'b0;
    bus.i_len         = '0;
    bus.i_abort       = 1'b0;
    bus.i_ready       = 1'b0;

    // reset
    tick();
    tick();
    chk("rst_start_ready", bus.o_start_ready, 1);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_number", bus.o_number, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_start_ready", bus.o_start_ready, 1);

    // len=15, full throughput
    bus.i_ready = 1'b1;
    start(15);
    for (int k = 1; k <= 15; k++) begin
      chk("l15_valid", bus.o_valid, 1);
      chk("l15_number", bus.o_number, k);
      chk("l15_fizz", bus.o_is_fizz, (k % 3) == 0);
      chk("l15_buzz", bus.o_is_buzz, (k % 5) == 0);
      chk("l15_last", bus.o_last, k == 15);
      tick();
    end
    chk("l15_done", bus.o_done, 1);
    chk("l15_aborted", bus.o_aborted, 0);
    chk("l15_done_valid", bus.o_valid, 0);
    chk("l15_done_sr", bus.o_start_ready, 0);
`ifdef FIZZBUZZ_SEQ_CTRL_STATS_EN
    chk("l15_fizz_cnt", bus.o_fizz_cnt, 4);
    chk("l15_buzz_cnt", bus.o_buzz_cnt, 2);
    chk("l15_fb_cnt", bus.o_fizzbuzz_cnt, 1);
`endif
    tick();
    chk("l15_idle_sr", bus.o_start_ready, 1);
    chk("l15_idle_done", bus.o_done, 0);

    // len=5, alternating backpressure
    bus.i_ready = 1'b0;
    start(5);
    for (int k = 1; k <= 5; k++) begin
      bus.i_ready = 1'b0;
      chk("bp_number", bus.o_number, k);
      tick();
      chk("bp_hold_number", bus.o_number, k);
      chk("bp_hold_valid", bus.o_valid, 1);
      chk("bp_hold_last", bus.o_last, k == 5);
      bus.i_ready = 1'b1;
      tick();
    end
    chk("bp_done", bus.o_done, 1);
    tick();

    // len=0
    start(0);
    chk("l0_valid", bus.o_valid, 0);
    chk("l0_done", bus.o_done, 1);
    chk("l0_aborted", bus.o_aborted, 0);
    chk("l0_sr", bus.o_start_ready, 0);
    tick();
    chk("l0_idle_sr", bus.o_start_ready, 1);
    chk("l0_idle_valid", bus.o_valid, 0);

    // len=60 clamps to 50
    bus.i_ready = 1'b1;
    beats = 0;
    last_cnt = 0;
    last_num = 0;
    last_fz = 0;
    last_bz = 0;
    start(60);
    for (int c = 0; c < 60; c++) begin
      if (bus.o_valid) begin
        beats++;
        if (bus.o_last) begin
          last_cnt++;
          last_num = int'(bus.o_number);
          last_fz  = int'(bus.o_is_fizz);
          last_bz  = int'(bus.o_is_buzz);
        end
      end
      tick();
    end
    chk("clamp_beats", beats, 50);
    chk("clamp_last_cnt", last_cnt, 1);
    chk("clamp_last_num", last_num, 50);
    chk("clamp_last_fizz", last_fz, 0);
    chk("clamp_last_buzz", last_bz, 1);
    chk("clamp_idle_sr", bus.o_start_ready, 1);

    // abort at 7 under backpressure
    start(20);
    repeat (6) tick();
    bus.i_ready = 1'b0;
    chk("ab_number", bus.o_number, 7);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    chk("ab_valid", bus.o_valid, 0);
    chk("ab_done", bus.o_done, 1);
    chk("ab_aborted", bus.o_aborted, 1);
    tick();
    chk("ab_idle_sr", bus.o_start_ready, 1);
    chk("ab_idle_aborted", bus.o_aborted, 0);
    bus.i_ready = 1'b1;
    start(3);
    for (int k = 1; k <= 3; k++) begin
      chk("post_ab_number", bus.o_number, k);
      chk("post_ab_fizz", bus.o_is_fizz, k == 3);
      chk("post_ab_buzz", bus.o_is_buzz, 0);
      chk("post_ab_last", bus.o_last, k == 3);
      tick();
    end
    chk("post_ab_done", bus.o_done, 1);
    chk("post_ab_aborted", bus.o_aborted, 0);
    tick();

    // reset mid-run
    start(10);
    repeat (3) tick();
    chk("mr_number", bus.o_number, 4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_valid", bus.o_valid, 0);
    chk("mr_busy", bus.o_busy, 0);
    chk("mr_sr", bus.o_start_ready, 1);
    chk("mr_done", bus.o_done, 0);
    tick();
    chk("mr_no_done", bus.o_done, 0);
    chk("mr_idle_sr", bus.o_start_ready, 1);
    start(2);
    chk("mr_new_number", bus.o_number, 1);
    chk("mr_new_valid", bus.o_valid, 1);
    tick();
    chk("mr_new_number2", bus.o_number, 2);
    chk("mr_new_last", bus.o_last, 1);
    tick();
    chk("mr_new_done", bus.o_done, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fizzbuzz_seq_ctrl.md
Name: fizzbuzz_seq_ctrl

Overview:
- Run sequencer for the fizzbuzz datapath.
- Accepts a run request with a length N, then emits the sequence 1..N as a valid/ready stream.
- Each element carries fizz/buzz flags, generated by modulo state counters rather than dividers.
- Supports sink backpressure, abort, and end-of-run signalling; sits between a host/config interface and a downstream formatter.

Parameters:
- G_MAX_LEN, 50, maximum run length; requests above this are clamped.
- G_FIZZ_DIV, 3, fizz divisor (>=2).
- G_BUZZ_DIV, 5, buzz divisor (>=2).
- Derived: W = $clog2(G_MAX_LEN+1); 6 with the default G_MAX_LEN.

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_start_valid  in  1  run request
- o_start_ready  out  1  high only in IDLE; request accepted on i_start_valid & o_start_ready
- i_len  in  W  requested length, sampled at request acceptance
- i_abort  in  1  terminate current run
- o_valid  out  1  element valid
- i_ready  in  1  sink accepts element
- o_number  out  W  current element value, 1..N
- o_is_fizz  out  1  o_number divisible by G_FIZZ_DIV
- o_is_buzz  out  1  o_number divisible by G_BUZZ_DIV
- o_last  out  1  element is the final one of the run (o_number == N)
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse at end of run
- o_aborted  out  1  qualifies o_done; run ended by abort

Behaviour:
- Reset: i_rst_n low at an edge puts the block in IDLE and clears o_valid, o_number, o_is_fizz, o_is_buzz, o_last, o_done, o_aborted, o_busy and the modulo counters.
  - First cycle after reset: o_start_ready=1.
  - Reset mid-run discards the run; no o_done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - On request acceptance, capture N = min(i_len, G_MAX_LEN).
  - N==0: go to DONE; no element is ever valid.
  - Otherwise go to RUN with o_number=1, fizz_mod=1, buzz_mod=1.
  - Latency: request accepted in cycle T gives o_valid=1 in cycle T+1.
  - i_abort in IDLE is ignored.
- RUN:
  - o_valid=1 throughout.
  - o_is_fizz = (fizz_mod==0), o_is_buzz = (buzz_mod==0), o_last = (o_number==N).
  - Modulo counters count 0..DIV-1 and wrap to 0; they advance with o_number.
  - Transfer = o_valid & i_ready.
  - While i_ready=0, all element outputs hold stable.
  - Transfer with o_last=0: o_number+1 and both mod counters advance on the next cycle, so back-to-back transfers give full throughput.
  - Transfer with o_last=1: go to DONE with o_valid=0.
- DONE: lasts one cycle; o_done=1, o_valid=0, o_start_ready=0; then IDLE.
  - Minimum idle gap between runs is therefore one DONE cycle plus one IDLE cycle.
- Abort: i_abort=1 in RUN goes to DONE with o_aborted=1 alongside o_done.
  - Abort has priority over advance.
  - A transfer coinciding with abort counts as delivered to the sink, but no further element follows.
- i_start_valid outside IDLE is ignored; nothing is queued.
- Arithmetic: o_number never exceeds N, so no overflow. The clamp compares the full W-bit i_len against G_MAX_LEN.

Optional Feature:
- Macro: FIZZBUZZ_SEQ_CTRL_STATS_EN.
- Defined: adds outputs o_fizz_cnt, o_buzz_cnt, o_fizzbuzz_cnt (each W bits).
  - They count transferred elements with fizz only, buzz only, and both, respectively.
  - Cleared on request acceptance and on reset; hold after the run ends until the next request.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- len=15, i_ready=1 constantly:
  - 15 consecutive beats 1..15.
  - Fizz-only at 3,6,9,12; buzz-only at 5,10; both at 15.
  - o_last only on 15; o_done one cycle after, o_aborted=0.
  - With STATS: counts 4/2/1.
- len=5, i_ready alternating 0,1: each element held stable while i_ready=0; sequence 1..5 unchanged; 5 transfers over about 10 cycles.
- len=0: no o_valid ever; o_done pulses the cycle after acceptance; o_start_ready returns the cycle after that.
- len=60 with G_MAX_LEN=50: exactly 50 beats; o_last on 50 (fizz=0, buzz=1).
- Abort while o_number=7 (i_ready=0): next cycle o_valid=0, o_done=1, o_aborted=1.
  - Following request len=3 gives 1,2,3 with fizz only on 3, confirming the modulo counters restarted.
- i_rst_n low for one cycle while o_number=4: next cycle o_valid=0, o_busy=0, o_start_ready=1, no o_done pulse; a new run then starts from 1.
